fp_div_seq: RTL

Parametrised sequential IEEE-754-style floating-point divider; next generation of the single-precision fp_divider.
- Generic exponent/fraction widths; single clock with start/busy/done handshake.
- Round-to-nearest-even with guard/sticky bits; full special-value handling and exception flags.
- Sits beside the FP adder/multiplier in the FP execution unit, driven by the issue logic.

---
 rtl/fp_pkg.sv | 59 +++++
 rtl/fp_round_pack.sv | 59 +++++
 rtl/fp_div_seq.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// ---------------------------------------------------------------------------
// fp_pkg
// Shared definitions for the FP execution unit (divider, and later the
// multiplier that reuses fp_round_pack):
//   - default exponent/fraction widths (single precision)
//   - controller state encoding for the sequential divider
//   - operand class encoding and classifier
//   - exception flag bundle
//   - bias and canonical quiet-NaN helpers, generic in the field widths
// ---------------------------------------------------------------------------
package fp_pkg;

    localparam int DEF_EXP_W  = 8;
    localparam int DEF_FRAC_W = 23;

    // Divider controller states.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ITER  = 2'd1;
    localparam logic [1:0] ST_ROUND = 2'd2;

    // Operand class. Subnormals are folded into FP_ZERO by the classifier.
    typedef enum logic [1:0] {
        FP_ZERO = 2'd0,
        FP_NORM = 2'd1,
        FP_INF  = 2'd2,
        FP_NAN  = 2'd3
    } fp_class_e;

    typedef struct packed {
        logic invalid;
        logic div_by_zero;
        logic overflow;
        logic underflow;
    } fp_flags_t;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Canonical qNaN (sign 0, exponent all ones, fraction MSB only),
    // right-aligned in a 64-bit container; callers truncate to their width.
    function automatic logic [63:0] fp_qnan(input int exp_w, input int frac_w);
        return (((64'd1 << exp_w) - 64'd1) << frac_w) | (64'd1 << (frac_w - 1));
    endfunction

    // A zero exponent means zero or subnormal; both are treated as zero.
    function automatic fp_class_e fp_classify(input logic exp_zero,
                                              input logic exp_ones,
                                              input logic frac_zero);
        if (exp_zero) begin
            return FP_ZERO;
        end
        if (!exp_ones) begin
            return FP_NORM;
        end
        return frac_zero ? FP_INF : FP_NAN;
    endfunction

endpackage

// File: rtl/fp_round_pack.sv
// ---------------------------------------------------------------------------
// fp_round_pack
// Combinational round-to-nearest-even, exponent adjust on mantissa carry,
// overflow/underflow detection and IEEE field packing. No subnormal outputs:
// results with a biased exponent <= 0 flush to signed zero.
//
// Ports:
//   sign      in   result sign
//   exp_in    in   signed biased exponent, EXP_W+2 bits (headroom both ways)
//   frac_in   in   FRAC_W fraction bits below the implied leading 1
//   guard     in   first bit below the fraction LSB
//   sticky    in   OR of every bit below guard (including any remainder)
//   result    out  packed {sign, exp, frac}
//   overflow  out  rounded exponent >= all-ones; result is signed infinity
//   underflow out  rounded exponent <= 0; result is signed zero
// ---------------------------------------------------------------------------
module fp_round_pack
    import fp_pkg::*;
#(
    parameter int EXP_W  = DEF_EXP_W,
    parameter int FRAC_W = DEF_FRAC_W
) (
    input  logic                        sign,
    input  logic signed [EXP_W+1:0]     exp_in,
    input  logic        [FRAC_W-1:0]    frac_in,
    input  logic                        guard,
    input  logic                        sticky,
    output logic        [EXP_W+FRAC_W:0] result,
    output logic                        overflow,
    output logic                        underflow
);

    localparam int E_W = EXP_W + 2;
    localparam logic signed [E_W-1:0] EXP_MAX  = E_W'((1 << EXP_W) - 1);
    localparam logic signed [E_W-1:0] EXP_ZERO = '0;

    logic                    round_up;
    logic [FRAC_W:0]         frac_inc;
    logic signed [E_W-1:0]   exp_r;

    always_comb begin
        round_up = guard & (sticky | frac_in[0]);
        frac_inc = {1'b0, frac_in} + {{FRAC_W{1'b0}}, round_up};
        // A carry out of the fraction means 1.11..1 rounded up to 10.00..0:
        // the low FRAC_W bits are already zero (mantissa 1.0), so only the
        // exponent needs bumping.
        exp_r     = exp_in + $signed({{(E_W-1){1'b0}}, frac_inc[FRAC_W]});
        overflow  = (exp_r >= EXP_MAX);
        underflow = (exp_r <= EXP_ZERO);
        if (overflow) begin
            result = {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        end else if (underflow) begin
            result = {sign, {(EXP_W+FRAC_W){1'b0}}};
        end else begin
            result = {sign, exp_r[EXP_W-1:0], frac_inc[FRAC_W-1:0]};
        end
    end

endmodule

// File: rtl/fp_div_seq.sv
// ---------------------------------------------------------------------------
// fp_div_seq
// Sequential IEEE-754-style divider, generic in exponent/fraction width.
// Special operands resolve in IDLE with done on the following cycle; normal
// operands run FRAC_W+3 restoring-division steps (one quotient bit per
// cycle) and one ROUND cycle.
//
// Ports:
//   fp_clk       in   clock, rising edge
//   reset        in   synchronous active-high reset; aborts any operation
//   start        in   request; operands sampled when start=1 and busy=0
//   A, B         in   dividend / divisor {sign, exp, frac}
//   busy         out  operation in flight (ITER or ROUND)
//   done         out  one-cycle pulse; Out and flags valid from this cycle
//   Out          out  quotient, held until the next done
//   invalid      out  0/0, inf/inf or NaN operand
//   div_by_zero  out  finite nonzero / zero
//   overflow     out  result rounded to infinity
//   underflow    out  result flushed to zero
// ---------------------------------------------------------------------------
module fp_div_seq
    import fp_pkg::*;
#(
    parameter int EXP_W  = DEF_EXP_W,
    parameter int FRAC_W = DEF_FRAC_W
) (
    input  logic                     fp_clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [EXP_W+FRAC_W:0]    A,
    input  logic [EXP_W+FRAC_W:0]    B,
    output logic                     busy,
    output logic                     done,
    output logic [EXP_W+FRAC_W:0]    Out,
    output logic                     invalid,
    output logic                     div_by_zero,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int W     = 1 + EXP_W + FRAC_W;
    localparam int SIG_W = FRAC_W + 1;      // significand with hidden 1
    localparam int REM_W = SIG_W + 1;       // partial remainder stays < 2*div
    localparam int Q_W   = FRAC_W + 3;      // 2^0 bit, fraction, guard, one extra
    localparam int CNT_W = $clog2(Q_W);
    localparam int E_W   = EXP_W + 2;
    localparam int BIAS  = fp_bias(EXP_W);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(Q_W - 1);
    localparam logic [W-1:0]     QNAN     = W'(fp_qnan(EXP_W, FRAC_W));

    // ---------------- operand fields and classification ----------------
    logic               sign_a, sign_b, sign_r;
    logic [EXP_W-1:0]   exp_a, exp_b;
    logic [FRAC_W-1:0]  frac_a, frac_b;
    fp_class_e          cls_a, cls_b;

    assign {sign_a, exp_a, frac_a} = A;
    assign {sign_b, exp_b, frac_b} = B;
    assign sign_r = sign_a ^ sign_b;
    assign cls_a  = fp_classify(exp_a == '0, &exp_a, frac_a == '0);
    assign cls_b  = fp_classify(exp_b == '0, &exp_b, frac_b == '0);

    logic [W-1:0] inf_res, zero_res;
    assign inf_res  = {sign_r, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    assign zero_res = {sign_r, {(W-1){1'b0}}};

    // Special-case decode, in priority order.
    logic         special;
    logic [W-1:0] spec_out;
    fp_flags_t    spec_flags;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        special    = 1'b1;
        spec_out   = '0;
        spec_flags = '0;
        if (cls_a == FP_NAN || cls_b == FP_NAN) begin
            spec_out           = QNAN;
            spec_flags.invalid = 1'b1;
        end else if ((cls_a == FP_ZERO && cls_b == FP_ZERO) ||
                     (cls_a == FP_INF  && cls_b == FP_INF)) begin
            spec_out           = QNAN;
            spec_flags.invalid = 1'b1;
        end else if (cls_a == FP_NORM && cls_b == FP_ZERO) begin
            spec_out               = inf_res;
            spec_flags.div_by_zero = 1'b1;
        end else if (cls_a == FP_INF) begin
            spec_out = inf_res;          // inf / finite (zero divisor included)
        end else if (cls_a == FP_ZERO || cls_b == FP_INF) begin
            spec_out = zero_res;
        end else begin
            special = 1'b0;
        end
    end

    // ---------------- state ----------------
    logic [1:0]        state_q,  state_d;
    logic              sign_q,   sign_d;
    logic [EXP_W-1:0]  exp_a_q,  exp_a_d;
    logic [EXP_W-1:0]  exp_b_q,  exp_b_d;
    logic [REM_W-1:0]  rem_q,    rem_d;
    logic [SIG_W-1:0]  div_q,    div_d;
    logic [Q_W-1:0]    quo_q,    quo_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic [W-1:0]      out_q,    out_d;
    fp_flags_t         flags_q,  flags_d;
    logic              done_q,   done_d;

    // ---------------- restoring step ----------------
    logic              rem_ge;
    logic [REM_W-1:0]  rem_sub;

    assign rem_ge  = (rem_q >= {1'b0, div_q});
    assign rem_sub = rem_ge ? (rem_q - {1'b0, div_q}) : rem_q;

    // ---------------- normalisation select for rounding ----------------
    // The quotient lies in (0.5, 2): quo_q MSB is the 2^0 bit. When it is
    // clear the result is one place lower, so take the window one bit down
    // and drop the exponent by one.
    logic [FRAC_W-1:0]     frac_sel;
    logic                  guard, sticky, eadj;
    logic signed [E_W-1:0] exp_pre;

    always_comb begin
        if (quo_q[Q_W-1]) begin
            frac_sel = quo_q[Q_W-2:2];
            guard    = quo_q[1];
            sticky   = quo_q[0] | (rem_q != '0);
            eadj     = 1'b0;
        end else begin
            frac_sel = quo_q[Q_W-3:1];
            guard    = quo_q[0];
            sticky   = (rem_q != '0);
            eadj     = 1'b1;
        end
        exp_pre = $signed({2'b00, exp_a_q} - {2'b00, exp_b_q}
                          + E_W'(BIAS) - {{(E_W-1){1'b0}}, eadj});
    end

    logic [W-1:0] rp_out;
    logic         rp_ovf, rp_unf;

    fp_round_pack #(
        .EXP_W  (EXP_W),
        .FRAC_W (FRAC_W)
    ) u_round_pack (
        .sign      (sign_q),
        .exp_in    (exp_pre),
        .frac_in   (frac_sel),
        .guard     (guard),
        .sticky    (sticky),
        .result    (rp_out),
        .overflow  (rp_ovf),
        .underflow (rp_unf)
    );

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        exp_a_d = exp_a_q;
        exp_b_d = exp_b_q;
        rem_d   = rem_q;
        div_d   = div_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        flags_d = flags_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    flags_d = '0;
                    sign_d  = sign_r;
                    exp_a_d = exp_a;
                    exp_b_d = exp_b;
                    if (special) begin
                        out_d   = spec_out;
                        flags_d = spec_flags;
                        done_d  = 1'b1;
                    end else begin
                        rem_d   = {1'b0, 1'b1, frac_a};
                        div_d   = {1'b1, frac_b};
                        quo_d   = '0;
                        cnt_d   = '0;
                        state_d = ST_ITER;
                    end
                end
            end

            ST_ITER: begin
                quo_d = {quo_q[Q_W-2:0], rem_ge};
                // rem_sub < div here, so its MSB is zero and the shift is lossless.
                rem_d = rem_sub << 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_ROUND;
                end
            end

            ST_ROUND: begin
                out_d               = rp_out;
                flags_d.invalid     = 1'b0;
                flags_d.div_by_zero = 1'b0;
                flags_d.overflow    = rp_ovf;
                flags_d.underflow   = rp_unf;
                done_d              = 1'b1;
                state_d             = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- registers ----------------
    always_ff @(posedge fp_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value regardless of statement order.
        if (reset) begin
            state_q <= ST_IDLE;
            sign_q  <= 1'b0;
            exp_a_q <= '0;
            exp_b_q <= '0;
            rem_q   <= '0;
            div_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            flags_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            exp_a_q <= exp_a_d;
            exp_b_q <= exp_b_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            flags_q <= flags_d;
            done_q  <= done_d;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;
    assign Out         = out_q;
    assign invalid     = flags_q.invalid;
    assign div_by_zero = flags_q.div_by_zero;
    assign overflow    = flags_q.overflow;
    assign underflow   = flags_q.underflow;

endmodule
